deser8b1: RTL and testbench
===========================

# deser8b1

Serial-to-parallel capture block: the receiving end of the 8:1 one-hot select path built around `mux8b1`. It accepts one bit per handshake on `I`, steers it into slot A..H with a rotating one-hot pointer `S`, and presents the completed 8-bit word on A..H with a valid/ready handshake. `S` uses the same encoding as the `mux8b1` select, so `S[0]` is slot A and `S[7]` (`8'h80`) is slot H. A `mux8b1` driven from the same pointer sequence re-serialises the word in the same order.

## Interface
- `FIRST_SEL`, default `8'h01`: one-hot slot written first after reset or flush. Must be one-hot.
- `CLK` in 1: rising-edge clock.
- `RST_N` in 1: asynchronous reset, active-low.
- `FLUSH` in 1: synchronous clear; discards any partial or pending word.
- `I` in 1: serial data bit.
- `I_VALID` in 1: `I` is valid this cycle.
- `I_READY` out 1: block accepts `I` this cycle.
- `S` out 8: one-hot pointer to the slot the next accepted bit is written into.
- `A`, `B`, `C`, `D`, `E`, `F`, `G`, `H` out 1 each: registered slot bits. A corresponds to `S[0]`, H to `S[7]`.
- `O_VALID` out 1: A..H hold a complete word.
- `O_READY` in 1: consumer takes the word this cycle.

## Operation
- States: `EMPTY` (pointer at `FIRST_SEL`, no bits held), `FILLING` (1–7 bits held), `FULL` (`O_VALID`=1).
- Accept condition: `I_VALID && I_READY`.
  - The slot selected by `S` loads `I`.
  - `S` rotates left by one; `S[7]` wraps to `S[0]`.
- `I_READY = !O_VALID || O_READY`. This is combinational, which gives full throughput when the consumer is always ready.
- Transitions:
  - `EMPTY` → `FILLING` on accept.
  - `FILLING` → `FULL` on the accept that writes the slot immediately before `FIRST_SEL` in rotation (the 8th bit).
  - `FULL` with `O_READY`=1 and no accept → `EMPTY`.
  - `FULL` with `O_READY`=1 and accept → `FILLING`. The new bit lands in the `FIRST_SEL` slot on the same edge.
  - `FULL` with `O_READY`=0 → hold. A..H and `S` are frozen, and `I_READY`=0.
- Slot bits are never cleared on consume. They keep their value until overwritten, so A..H stay meaningful only while `O_VALID`=1.
- `FLUSH`:
  - Has priority over accept and consume.
  - Next state is `EMPTY`, `S`=`FIRST_SEL`, `O_VALID`=0, A..H=0.
- Reset (`RST_N`=0):
  - Takes effect immediately, independent of `CLK`.
  - Outputs: `S`=`FIRST_SEL`, A..H=0, `O_VALID`=0, `I_READY`=1.
  - Reset mid-word discards the partial word. The first bit accepted after release goes to the `FIRST_SEL` slot.
- `S` is one-hot in every state. A non-one-hot `S` is a design error and is flagged by a bench assertion.

## Timing
- Latency: the 8th bit accepted at edge k gives `O_VALID`=1 after edge k. A..H are stable in that same cycle.
- Throughput: one word per 8 cycles with no bubbles while `I_VALID`=`O_READY`=1.
- Consume and 9th-bit accept happen on the same edge. After that edge, `O_VALID`=0, `S`=`FIRST_SEL` rotated by one, and the `FIRST_SEL` slot holds the new bit.
- `I_VALID` may drop between bits. `S` and the slots hold, with no timeout.
- `O_VALID`, once high, stays high until consumed, flushed or reset.
- All state changes happen on the rising edge of `CLK`, except the asynchronous reset.

## Structure
- Shared package `deser_pkg`:
  - state enum `{EMPTY, FILLING, FULL}`
  - constant `SEL_W = 8`
  - function `rotl1` (one-hot rotate)
- Sub-module `onehot_rot8`: 8-bit rotating one-hot register with enable, sync clear-to-seed and async active-low reset. It is reusable as the select generator for `mux8b1`.
- The top level holds the FSM, the slot registers A..H and the handshake logic.

## Test plan
- Reset check: hold `RST_N`=0, then release. Expect `S`=`8'h01`, A..H=0, `O_VALID`=0, `I_READY`=1.
- Stream `10000000` (first bit to A) with `O_READY`=1. Expect `O_VALID`=1 after the 8th edge with A=1 and B..H=0, and `S` back at `8'h01`.
- Backpressure: fill `00000001` with `O_READY`=0. Expect H=1, `O_VALID`=1 and `I_READY`=0 for 5 cycles with `I_VALID`=1, and `S`=`8'h01` frozen. Then raise `O_READY` with `I`=1. Expect `O_VALID`=0, `S`=`8'h02`, A=1.
- Back-to-back: 3 words (`8'hA5`, `8'h3C`, `8'hFF`) streamed continuously. Expect `O_VALID` pulses exactly every 8 cycles with matching A..H.
- Mid-word disturbance: after 4 bits, pulse `FLUSH`. Expect `S`=`8'h01` and A..H=0 next cycle. Repeat using `RST_N` asserted between clock edges. Expect the same values immediately, without waiting for an edge.
- Gaps: toggle `I_VALID` randomly. Expect `S` to advance only on accept edges and the final word to equal the accepted bits in order.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared state encoding, select width and one-hot rotate helper
package deser_pkg;
  localparam int SEL_W = 8;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  function automatic logic [SEL_W-1:0] rotl1(input logic [SEL_W-1:0] v);
    return {v[SEL_W-2:0], v[SEL_W-1]};
  endfunction
endpackage

// File: rtl/onehot_rot8.sv
// onehot_rot8: rotating one-hot register with enable, sync clear-to-seed and async active-low reset
module onehot_rot8
  import deser_pkg::*;
#(
  parameter logic [SEL_W-1:0] SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else if (clr) q <= SEED;
    else if (en) q <= rotl1(q);
endmodule

// File: rtl/deser8b1.sv
// deser8b1: serial-to-parallel capture of one bit per handshake into slots A..H behind a one-hot pointer
module deser8b1
  import deser_pkg::*;
#(
  parameter logic [SEL_W-1:0] FIRST_SEL = 8'h01
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic             I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [SEL_W-1:0] S,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             E,
  output logic             F,
  output logic             G,
  output logic             H,
  output logic             O_VALID,
  input  logic             O_READY
);
  state_t state, state_n;
  logic [SEL_W-1:0] slots;
  logic accept, last;
  assign O_VALID = state == FULL;
  assign I_READY = !O_VALID || O_READY;
  assign accept = I_VALID && I_READY;
  // the 8th bit is the one written into the slot just before FIRST_SEL
  assign last = rotl1(S) == FIRST_SEL;
  assign {H, G, F, E, D, C, B, A} = slots;
  onehot_rot8 #(.SEED(FIRST_SEL)) u_ptr (
    .clk(CLK),
    .rst_n(RST_N),
    .clr(FLUSH),
    .en(accept),
    .q(S)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= EMPTY;
      slots <= '0;
    end else begin
      state <= state_n;
      slots <= FLUSH ? '0 : accept ? (slots & ~S) | (S & {SEL_W{I}}) : slots;
    end
  always_comb
    state_n = FLUSH ? EMPTY
            : state == FULL ? (O_READY ? (accept ? FILLING : EMPTY) : FULL)
            : accept ? (last ? FULL : FILLING) : state;
endmodule

// File: tb/tb_deser8b1.sv
// tb_deser8b1: randomized self-checking bench for deser8b1 against a bit-count reference model
module tb_deser8b1;
  logic CLK = 0, RST_N = 0, FLUSH = 0, I = 0, I_VALID = 0, O_READY = 0;
  logic I_READY, O_VALID, A, B, C, D, E, F, G, H;
  logic [7:0] S;
  logic [17:0] obs;
  int vectors = 0, errors = 0;
  int m_cnt = 0;
  logic [7:0] m_word = '0;
  bit m_full = 0;

  deser8b1 #(.FIRST_SEL(8'h01)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .I(I), .I_VALID(I_VALID), .I_READY(I_READY),
    .S(S), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .O_VALID(O_VALID), .O_READY(O_READY)
  );

  always #5 CLK = ~CLK;
  assign obs = {S, H, G, F, E, D, C, B, A, O_VALID, I_READY};

  always @(negedge CLK)
    if (RST_N) assert ($onehot(S)) else $error("FAIL onehot S=%h", S);

  function automatic void model_reset();
    m_cnt = 0;
    m_word = '0;
    m_full = 0;
  endfunction

  function automatic void model_step(input logic iv, ib, ordy, fl);
    bit acc;
    acc = iv && (!m_full || ordy);
    if (fl) model_reset();
    else begin
      if (m_full && ordy) begin
        m_full = 0;
        m_cnt = 0;
      end
      if (acc) begin
        m_word[m_cnt] = ib;
        m_cnt++;
        if (m_cnt == 8) m_full = 1;
      end
    end
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [7:0] s;
    s = 8'(1 << (m_cnt % 8));
    return {s, m_word, m_full, !m_full || O_READY};
  endfunction

  task automatic cycle(input logic iv, ib, ordy, fl);
    I_VALID = iv;
    I = ib;
    O_READY = ordy;
    FLUSH = fl;
    @(posedge CLK);
    model_step(iv, ib, ordy, fl);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (obs !== 18'h00401) begin
      errors++;
      $display("FAIL reset_held got=%h want=%h", obs, 18'h00401);
    end
    RST_N = 1;
    model_reset();
    @(negedge CLK);
    vectors++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(1, k == 0, 1, 0);
      vectors++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL single[%0d] got=%h want=%h", k, obs, exp_vec());
      end
    end
    vectors++;
    if ({S, H, G, F, E, D, C, B, A, O_VALID} !== {8'h01, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL single_word got S=%h word=%b ov=%b want S=01 word=00000001 ov=1", S, {H, G, F, E, D, C, B, A}, O_VALID);
    end
  endtask

  task automatic test_backpressure();
    cycle(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) cycle(1, k == 7, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1'($urandom), 0, 0);
      vectors++;
      if ({S, H, O_VALID, I_READY} !== {8'h01, 1'b1, 1'b1, 1'b0} || obs !== exp_vec()) begin
        errors++;
        $display("FAIL backpressure[%0d] got=%h want=%h", k, obs, exp_vec());
      end
    end
    cycle(1, 1, 1, 0);
    vectors++;
    if ({S, A, O_VALID} !== {8'h02, 1'b1, 1'b0} || obs !== exp_vec()) begin
      errors++;
      $display("FAIL consume_accept got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words = '{8'hA5, 8'h3C, 8'hFF};
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 24; k++) begin
      cycle(1, words[k / 8][k % 8], 1, 0);
      vectors++;
      if (O_VALID !== (k % 8 == 7) || (O_VALID && {H, G, F, E, D, C, B, A} !== words[k / 8])
          || obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b[%0d] got=%h want=%h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 4; k++) cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 1);
    vectors++;
    if ({S, H, G, F, E, D, C, B, A, O_VALID} !== 17'h00200 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL flush got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) cycle(1, 1, 1, 0);
    I_VALID = 0;
    #2 RST_N = 0;
    #1;
    vectors++;
    if (obs !== 18'h00401) begin
      errors++;
      $display("FAIL async_reset got=%h want=%h", obs, 18'h00401);
    end
    model_reset();
    #1 RST_N = 1;
    @(negedge CLK);
    vectors++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL async_release got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_gaps();
    cycle(0, 0, 1, 1);
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      vectors++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL gaps[%0d] got=%h want=%h", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
